ps2_host_tx: RTL
================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 5000, clock-low inhibit time in board_clk cycles (100 us at 50 MHz).
REQ-002 Parameter SETUP_CYCLES, default 50, time start bit and clock are held low together before clock release.
REQ-003 Parameter FILT_CYCLES, default 8, consecutive stable samples required before a filtered PS/2 line changes value.
REQ-004 Parameter TIMEOUT_CYCLES, default 1000000, watchdog from clock release to frame end (20 ms).
REQ-005 board_clk  in  1  system clock, 50 MHz, all logic on rising edge.
REQ-006 reset  in  1  asynchronous, active-high.
REQ-007 tx_valid  in  1  request to send tx_data.
REQ-008 tx_data  in  8  command byte to keyboard (e.g. 0xED, 0xFF).
REQ-009 tx_ready  out  1  high only in IDLE; byte accepted when tx_valid && tx_ready.
REQ-010 ps2_clk_in  in  1  raw PS/2 clock pad value (asynchronous).
REQ-011 ps2_data_in  in  1  raw PS/2 data pad value (asynchronous).
REQ-012 ps2_clk_oe  out  1  1 = drive PS/2 clock low (open drain), 0 = release.
REQ-013 ps2_data_oe  out  1  1 = drive PS/2 data low (open drain), 0 = release.
REQ-014 busy  out  1  high in every state except IDLE; keyboard receiver ignores the bus while high.
REQ-015 tx_done  out  1  one-cycle pulse: frame acknowledged and bus idle.
REQ-016 tx_err  out  1  one-cycle pulse: NACK or timeout.

Function
REQ-017 Both pad inputs SHALL pass a 2-FF synchronizer then the FILT_CYCLES stability filter; filtered values reset to 1.
REQ-018 clk_fall SHALL be a one-cycle pulse when filtered clock goes 1->0.
REQ-019 States: IDLE, INHIBIT, SETUP, SEND, ACK, WAIT_IDLE.
REQ-020 IDLE: both oe 0; on accept latch tx_data, latch parity = XNOR-reduce(tx_data) (odd parity), go INHIBIT; tx_valid outside IDLE is ignored, not queued.
REQ-021 INHIBIT: ps2_clk_oe=1, ps2_data_oe=0 for exactly INHIBIT_CYCLES, then SETUP.
REQ-022 SETUP: ps2_clk_oe=1, ps2_data_oe=1 (start bit 0) for exactly SETUP_CYCLES, then ps2_clk_oe=0, bit counter=1, watchdog cleared and started, go SEND.
REQ-023 SEND: on clk_fall number k (k=1..10) the driven bit SHALL change in the same cycle as clk_fall: k=1..8 -> tx_data[k-1] (LSB first), k=9 -> parity, k=10 -> stop bit 1; ps2_data_oe = ~bit.
REQ-024 After k=10, go ACK with ps2_data_oe=0 and ps2_clk_oe=0.
REQ-025 ACK: on next clk_fall sample filtered data; 0 -> WAIT_IDLE; 1 -> pulse tx_err, go IDLE.
REQ-026 WAIT_IDLE: when filtered clock and data both 1, pulse tx_done, go IDLE.
REQ-027 Watchdog: if count reaches TIMEOUT_CYCLES in SEND, ACK or WAIT_IDLE, both oe 0, pulse tx_err, go IDLE same cycle; counter saturates, no wrap.
REQ-028 tx_done and tx_err SHALL never pulse in the same cycle nor twice per frame.
REQ-029 Clock edges during INHIBIT/SETUP are ignored; counters are wide enough for parameter values without overflow.

Reset
REQ-030 Reset SHALL immediately (asynchronously) force IDLE, ps2_clk_oe=0, ps2_data_oe=0, busy=0, tx_done=0, tx_err=0, counters 0, filters 1; tx_ready=1 after deassertion.
REQ-031 Reset mid-frame SHALL abandon the frame with no tx_done/tx_err pulse.

Verification
REQ-032 tx_data=0xED, keyboard model clocking at 12.5 kHz and acking -> data on falls 1..10: 1,0,1,1,0,1,1,1, parity 1, stop 1; one tx_done; tx_ready returns 1.
REQ-033 tx_data=0x01 -> parity bit 0; tx_data=0xFF -> parity bit 1.
REQ-034 Model leaves data high at 11th fall -> one tx_err, no tx_done, both oe 0.
REQ-035 Model never clocks -> tx_err exactly TIMEOUT_CYCLES after clock release, both oe 0, tx_ready 1 next cycle.
REQ-036 ps2_clk_oe high exactly 5000 cycles before ps2_data_oe rises; tx_valid pulsed while busy -> ignored, one frame only.
REQ-037 reset asserted at 5th clk_fall -> both oe 0 before next board_clk edge; no pulses; next accepted byte transmits normally.

Source files
------------

// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - command byte handshake and status bundle for ps2_host_tx
interface ps2_host_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_err;

  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready,
    input  busy,
    input  tx_done,
    input  tx_err
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready,
    output busy,
    output tx_done,
    output tx_err
  );
endinterface

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter
// Inhibits the bus, issues the request-to-send and shifts one byte out on keyboard clock falls.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int SETUP_CYCLES   = 50,
  parameter int FILT_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic         board_clk,
  input  logic         reset,
  ps2_host_tx_if.slave tx,
  input  logic         ps2_clk_in,
  input  logic         ps2_data_in,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe
);
  localparam int PH_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int WD_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FC_W   = $clog2(FILT_CYCLES + 1);

  localparam logic [PH_W-1:0] INH_LAST = PH_W'(INHIBIT_CYCLES - 1);
  localparam logic [PH_W-1:0] SET_LAST = PH_W'(SETUP_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_MAX   = WD_W'(TIMEOUT_CYCLES);
  localparam logic [FC_W-1:0] FC_LAST  = FC_W'(FILT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, SETUP, SEND, ACK, WAIT_IDLE} state_t;

  state_t          state, state_n;
  logic [1:0]      clk_sync, data_sync;
  logic            clk_filt, data_filt, clk_filt_d;
  logic [FC_W-1:0] clk_fcnt, data_fcnt;
  logic            clk_fall;
  logic [PH_W-1:0] phase_cnt;
  logic [WD_W-1:0] wd_cnt;
  logic            timeout;
  logic [9:0]      shreg;
  logic            cur_bit;
  logic [3:0]      bit_cnt;
  logic            done_p, err_p;

  // A filtered line only moves after FILT_CYCLES consecutive samples disagree with it.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      clk_sync   <= 2'b11;
      data_sync  <= 2'b11;
      clk_filt   <= 1'b1;
      data_filt  <= 1'b1;
      clk_filt_d <= 1'b1;
      clk_fcnt   <= '0;
      data_fcnt  <= '0;
    end else begin
      clk_sync   <= {clk_sync[0], ps2_clk_in};
      data_sync  <= {data_sync[0], ps2_data_in};
      clk_filt_d <= clk_filt;
      if (clk_sync[1] == clk_filt) begin
        clk_fcnt <= '0;
      end else if (clk_fcnt == FC_LAST) begin
        clk_filt <= clk_sync[1];
        clk_fcnt <= '0;
      end else begin
        clk_fcnt <= clk_fcnt + 1'b1;
      end
      if (data_sync[1] == data_filt) begin
        data_fcnt <= '0;
      end else if (data_fcnt == FC_LAST) begin
        data_filt <= data_sync[1];
        data_fcnt <= '0;
      end else begin
        data_fcnt <= data_fcnt + 1'b1;
      end
    end
  end

  assign clk_fall = clk_filt_d & ~clk_filt;
  assign timeout  = (wd_cnt == WD_MAX);

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      phase_cnt <= '0;
      wd_cnt    <= '0;
      shreg     <= '0;
      cur_bit   <= 1'b0;
      bit_cnt   <= '0;
    end else begin
      state <= state_n;
      if (state != state_n) begin
        phase_cnt <= '0;
      end else if (state == INHIBIT || state == SETUP) begin
        phase_cnt <= phase_cnt + 1'b1;
      end
      // Watchdog is held clear until clock release, then saturates.
      if (state == SETUP) begin
        wd_cnt <= '0;
      end else if ((state == SEND || state == ACK || state == WAIT_IDLE) && !timeout) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (state == IDLE && tx.tx_valid) begin
        shreg <= {1'b1, ~^tx.tx_data, tx.tx_data};
      end else if (state == SEND && clk_fall) begin
        shreg <= {1'b1, shreg[9:1]};
      end
      if (state == SETUP) begin
        bit_cnt <= 4'd1;
        cur_bit <= 1'b0;
      end else if (state == SEND && clk_fall) begin
        bit_cnt <= bit_cnt + 4'd1;
        cur_bit <= shreg[0];
      end
    end
  end

  always_comb begin
    state_n     = state;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    done_p      = 1'b0;
    err_p       = 1'b0;
    case (state)
      IDLE: begin
        if (tx.tx_valid) state_n = INHIBIT;
      end
      INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (phase_cnt == INH_LAST) state_n = SETUP;
      end
      SETUP: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = 1'b1;
        if (phase_cnt == SET_LAST) state_n = SEND;
      end
      SEND: begin
        if (timeout) begin
          err_p   = 1'b1;
          state_n = IDLE;
        end else begin
          // The new bit goes onto the wire in the same cycle the fall is seen.
          ps2_data_oe = clk_fall ? ~shreg[0] : ~cur_bit;
          if (clk_fall && bit_cnt == 4'd10) state_n = ACK;
        end
      end
      ACK: begin
        if (timeout) begin
          err_p   = 1'b1;
          state_n = IDLE;
        end else if (clk_fall) begin
          if (!data_filt) begin
            state_n = WAIT_IDLE;
          end else begin
            err_p   = 1'b1;
            state_n = IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (timeout) begin
          err_p   = 1'b1;
          state_n = IDLE;
        end else if (clk_filt && data_filt) begin
          done_p  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign tx.tx_ready = (state == IDLE);
  assign tx.busy     = (state != IDLE);
  assign tx.tx_done  = done_p;
  assign tx.tx_err   = err_p;
endmodule
